// File: rtl/dbg_port_pkg.sv
// rtl/dbg_port_pkg.sv - shared types and constants for the debug/result port
// State encoding, register map and STATUS bit layout.
package dbg_port_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CHAR   = 2'd0;
  localparam logic [1:0] ADDR_CHECK  = 2'd1;
  localparam logic [1:0] ADDR_HALT   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_STATE_LSB = 3;

endpackage

// File: rtl/dbg_fifo.sv
// rtl/dbg_fifo.sv - console character FIFO with registered head
// Extra pointer bit separates full from empty; a pop frees room for a same-edge push.
module dbg_fifo
  import dbg_port_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign push_ok_o = push_ok;
  assign valid_o   = !empty_o;
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; occupancy is defined entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dbg_port.sv
// rtl/dbg_port.sv - debug/result port between CPU bus and test bench
// Console FIFO, pass/fail counters, halt exit code and RUN/DRAIN/DONE sequencing.
module dbg_port
  import dbg_port_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             BUS_ADDR,
  input  logic [DATA_WIDTH-1:0]  BUS_DATA_IN,
  input  logic                   BUS_WE,
  input  logic                   BUS_RE,
  output logic [DATA_WIDTH-1:0]  BUS_DATA_OUT,
  output logic [DATA_WIDTH-1:0]  OUT_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [COUNT_WIDTH-1:0] PASS_COUNT,
  output logic [COUNT_WIDTH-1:0] FAIL_COUNT,
  output logic                   OVERFLOW,
  output logic                   DONE,
  output logic [DATA_WIDTH-1:0]  EXIT_CODE,
  output logic                   ALL_OK
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] pass_q, pass_d;
  logic [COUNT_WIDTH-1:0] fail_q, fail_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]  exit_q, exit_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   done_q;

  logic                   wr_en;
  logic                   char_wr, check_wr, halt_wr;
  logic                   fifo_pop, fifo_full, fifo_empty, fifo_valid, fifo_push_ok;
  logic [DATA_WIDTH-1:0]  fifo_head;
  logic [DATA_WIDTH-1:0]  status_w;

  // Bus writes only have an effect while the program is still running.
  assign wr_en    = BUS_WE && (state_q == ST_RUN);
  assign char_wr  = wr_en && (BUS_ADDR == ADDR_CHAR);
  assign check_wr = wr_en && (BUS_ADDR == ADDR_CHECK);
  assign halt_wr  = wr_en && (BUS_ADDR == ADDR_HALT);
  assign fifo_pop = OUT_READY && fifo_valid;

  dbg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (char_wr),
    .push_data_i (BUS_DATA_IN),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .push_ok_o   (fifo_push_ok)
  );

  always_comb begin
    status_w = '0;
    status_w[STAT_EMPTY_BIT]         = fifo_empty;
    status_w[STAT_FULL_BIT]          = fifo_full;
    status_w[STAT_OVF_BIT]           = ovf_q;
    status_w[STAT_STATE_LSB +: 2]    = state_q;
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ovf_d   = ovf_q;
    exit_d  = exit_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_RUN:   if (halt_wr) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase

    if (halt_wr) exit_d = BUS_DATA_IN;

    if (check_wr) begin
      if (BUS_DATA_IN != '0) begin
        if (pass_q != '1) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != '1) fail_d = fail_q + 1'b1;
      end
    end

    if (char_wr && !fifo_push_ok) ovf_d = 1'b1;

    if (BUS_RE) rdata_d = (BUS_ADDR == ADDR_STATUS) ? status_w : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      pass_q  <= '0;
      fail_q  <= '0;
      ovf_q   <= 1'b0;
      exit_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
      exit_q  <= exit_d;
      rdata_q <= rdata_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign BUS_DATA_OUT = rdata_q;
  assign OUT_DATA     = fifo_head;
  assign OUT_VALID    = fifo_valid;
  assign PASS_COUNT   = pass_q;
  assign FAIL_COUNT   = fail_q;
  assign OVERFLOW     = ovf_q;
  assign DONE         = done_q;
  assign EXIT_CODE    = exit_q;
  assign ALL_OK       = (fail_q == '0) && !ovf_q &&
                        ((state_q != ST_DONE) || (exit_q == '0));

endmodule

// File: tb/tb_dbg_port.sv
// tb/tb_dbg_port.sv - directed self-checking bench for dbg_port
// Small FIFO and narrow counters so overflow and saturation are reachable quickly.
module tb_dbg_port;

  localparam int FD = 4;
  localparam int CW = 2;
  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [1:0]    BUS_ADDR;
  logic [DW-1:0] BUS_DATA_IN;
  logic          BUS_WE;
  logic          BUS_RE;
  logic [DW-1:0] BUS_DATA_OUT;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [CW-1:0] PASS_COUNT;
  logic [CW-1:0] FAIL_COUNT;
  logic          OVERFLOW;
  logic          DONE;
  logic [DW-1:0] EXIT_CODE;
  logic          ALL_OK;

  int n_checks = 0;
  int n_errors = 0;

  dbg_port #(
    .FIFO_DEPTH  (FD),
    .COUNT_WIDTH (CW),
    .DATA_WIDTH  (DW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .BUS_ADDR     (BUS_ADDR),
    .BUS_DATA_IN  (BUS_DATA_IN),
    .BUS_WE       (BUS_WE),
    .BUS_RE       (BUS_RE),
    .BUS_DATA_OUT (BUS_DATA_OUT),
    .OUT_DATA     (OUT_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .PASS_COUNT   (PASS_COUNT),
    .FAIL_COUNT   (FAIL_COUNT),
    .OVERFLOW     (OVERFLOW),
    .DONE         (DONE),
    .EXIT_CODE    (EXIT_CODE),
    .ALL_OK       (ALL_OK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [DW-1:0] data);
    BUS_ADDR    = addr;
    BUS_DATA_IN = data;
    BUS_WE      = 1'b1;
    tick();
    BUS_WE      = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr);
    BUS_ADDR = addr;
    BUS_RE   = 1'b1;
    tick();
    BUS_RE   = 1'b0;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
  endtask

  logic [DW-1:0] drain_exp [4];

  initial begin
    RST = 1'b1; BUS_ADDR = '0; BUS_DATA_IN = '0; BUS_WE = 1'b0; BUS_RE = 1'b0; OUT_READY = 1'b0;
    tick(); tick();
    check("rst_valid", OUT_VALID, 0);
    check("rst_pass", PASS_COUNT, 0);
    check("rst_fail", FAIL_COUNT, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_done", DONE, 0);
    check("rst_exit", EXIT_CODE, 0);
    check("rst_rdata", BUS_DATA_OUT, 0);
    check("rst_allok", ALL_OK, 1);
    RST = 1'b0;
    tick();

    // Reset asserted between edges while characters are queued
    bus_write(2'd0, 8'h31);
    bus_write(2'd0, 8'h32);
    bus_write(2'd0, 8'h33);
    bus_write(2'd1, 8'h00);
    check("mid_valid_pre", OUT_VALID, 1);
    check("mid_fail_pre", FAIL_COUNT, 1);
    #2;
    RST = 1'b1;
    #1;
    check("mid_valid_async", OUT_VALID, 0);
    #1;
    RST = 1'b0;
    tick();
    check("mid_fail_post", FAIL_COUNT, 0);
    check("mid_pass_post", PASS_COUNT, 0);
    check("mid_done_post", DONE, 0);
    check("mid_allok_post", ALL_OK, 1);
    check("mid_valid_post", OUT_VALID, 0);

    // Console ordering
    bus_write(2'd0, 8'h48);
    check("ord_first_valid", OUT_VALID, 1);
    check("ord_first_data", OUT_DATA, 8'h48);
    bus_write(2'd0, 8'h69);
    check("ord_head_data", OUT_DATA, 8'h48);
    OUT_READY = 1'b1;
    tick();
    check("ord_second_data", OUT_DATA, 8'h69);
    check("ord_second_valid", OUT_VALID, 1);
    tick();
    check("ord_empty", OUT_VALID, 0);
    OUT_READY = 1'b0;

    // Overflow and push-while-full-with-pop
    pulse_reset();
    for (int i = 0; i < 4; i++) bus_write(2'd0, 8'h10 + i[7:0]);
    check("ovf_not_yet", OVERFLOW, 0);
    bus_write(2'd0, 8'h14);
    check("ovf_set", OVERFLOW, 1);
    check("ovf_allok", ALL_OK, 0);
    bus_read(2'd3);
    check("ovf_status", BUS_DATA_OUT, 8'h06);
    OUT_READY = 1'b1;
    bus_write(2'd0, 8'h15);
    OUT_READY = 1'b0;
    bus_read(2'd3);
    check("full_pushpop_status", BUS_DATA_OUT, 8'h06);
    drain_exp[0] = 8'h11; drain_exp[1] = 8'h12; drain_exp[2] = 8'h13; drain_exp[3] = 8'h15;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), OUT_DATA, drain_exp[i]);
      tick();
    end
    check("ovf_drained", OUT_VALID, 0);
    OUT_READY = 1'b0;

    // Pass/fail counting with saturation
    pulse_reset();
    bus_write(2'd1, 8'h01);
    bus_write(2'd1, 8'h01);
    bus_write(2'd1, 8'h01);
    bus_write(2'd1, 8'h00);
    check("cnt_pass3", PASS_COUNT, 3);
    check("cnt_fail1", FAIL_COUNT, 1);
    check("cnt_allok", ALL_OK, 0);
    bus_write(2'd1, 8'h80);
    bus_write(2'd1, 8'h01);
    check("cnt_pass_sat", PASS_COUNT, 3);
    for (int i = 0; i < 3; i++) bus_write(2'd1, 8'h00);
    check("cnt_fail_sat", FAIL_COUNT, 3);

    // STATUS write ignored; simultaneous write and read; read hold
    BUS_ADDR = 2'd3; BUS_DATA_IN = 8'hFF; BUS_WE = 1'b1; BUS_RE = 1'b1;
    tick();
    BUS_WE = 1'b0; BUS_RE = 1'b0;
    check("stw_rdata", BUS_DATA_OUT, 8'h01);
    check("stw_pass", PASS_COUNT, 3);
    check("stw_valid", OUT_VALID, 0);
    tick();
    check("rd_hold", BUS_DATA_OUT, 8'h01);
    bus_read(2'd0);
    check("rd_other_zero", BUS_DATA_OUT, 0);

    // Halt with backlog
    pulse_reset();
    bus_write(2'd0, 8'h41);
    bus_write(2'd0, 8'h42);
    bus_write(2'd2, 8'h00);
    bus_read(2'd3);
    check("halt_status_drain", BUS_DATA_OUT, 8'h08);
    check("halt_done0", DONE, 0);
    bus_write(2'd0, 8'h43);
    bus_write(2'd1, 8'h00);
    bus_write(2'd2, 8'h55);
    check("halt_fail_ign", FAIL_COUNT, 0);
    check("halt_exit_ign", EXIT_CODE, 0);
    OUT_READY = 1'b1;
    check("halt_d0", OUT_DATA, 8'h41);
    tick();
    check("halt_d1", OUT_DATA, 8'h42);
    tick();
    check("halt_empty", OUT_VALID, 0);
    check("halt_done_not_yet", DONE, 0);
    tick();
    check("halt_done", DONE, 1);
    check("halt_exit", EXIT_CODE, 0);
    check("halt_allok", ALL_OK, 1);
    OUT_READY = 1'b0;
    bus_read(2'd3);
    check("halt_status_done", BUS_DATA_OUT, 8'h11);

    // Nonzero exit with empty FIFO
    pulse_reset();
    bus_write(2'd2, 8'h2A);
    check("nz_done0", DONE, 0);
    check("nz_exit", EXIT_CODE, 8'h2A);
    check("nz_allok_drain", ALL_OK, 1);
    tick();
    check("nz_done1", DONE, 1);
    check("nz_allok", ALL_OK, 0);
    bus_write(2'd2, 8'h00);
    check("nz_exit_hold", EXIT_CODE, 8'h2A);
    check("nz_done_hold", DONE, 1);
    check("nz_allok_hold", ALL_OK, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbg_port.md
Name: dbg_port

Overview:
- Synthesizable debug/result port that a processor-under-test writes to while running test programs.
- Collects console characters into a FIFO for the testbench to drain.
- Counts pass/fail self-checks and latches a halt exit code.
- Presents DONE / ALL_OK / EXIT_CODE, which the bench's end-of-test and exit-code logic consume directly; it sits between the CPU data bus and the bench.

Parameters:
- FIFO_DEPTH, 16, console FIFO entries; power of two, minimum 2.
- COUNT_WIDTH, 16, width of pass/fail counters.
- DATA_WIDTH, 8, bus and character width; minimum 8.

Ports:
- CLK  in  1  sole clock; all state changes on rising edge.
- RST  in  1  reset: asynchronous, active-high.
- BUS_ADDR  in  2  register select: 0=CHAR, 1=CHECK, 2=HALT, 3=STATUS.
- BUS_DATA_IN  in  DATA_WIDTH  write data.
- BUS_WE  in  1  write strobe, sampled on CLK.
- BUS_RE  in  1  read strobe, sampled on CLK.
- BUS_DATA_OUT  out  DATA_WIDTH  registered read data.
- OUT_DATA  out  DATA_WIDTH  FIFO head character.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  bench accepts head when OUT_VALID & OUT_READY.
- PASS_COUNT  out  COUNT_WIDTH  CHECK writes with nonzero data.
- FAIL_COUNT  out  COUNT_WIDTH  CHECK writes with zero data.
- OVERFLOW  out  1  sticky: a CHAR write was dropped.
- DONE  out  1  halted and FIFO drained.
- EXIT_CODE  out  DATA_WIDTH  value written to HALT.
- ALL_OK  out  1  overall verdict.

Behaviour:
- Reset, asynchronous, any time including mid-drain:
  - FIFO emptied, OUT_VALID=0 immediately.
  - Counters=0, OVERFLOW=0, EXIT_CODE=0, DONE=0, BUS_DATA_OUT=0, state=RUN.
- States: RUN, DRAIN, DONE.
  - RUN -> DRAIN on a HALT write; EXIT_CODE latches BUS_DATA_IN.
  - DRAIN -> DONE on the first edge where the FIFO is empty. This includes HALT with an already-empty FIFO, which reaches DONE one edge after the HALT edge.
  - DONE is terminal until RST.
- Writes accepted only in RUN. In DRAIN/DONE all writes are ignored: no counter, FIFO or EXIT_CODE change.
- CHAR write:
  - Pushes BUS_DATA_IN.
  - When full, the push is still accepted if a pop occurs on the same edge.
  - Otherwise the character is dropped and OVERFLOW is set (sticky).
- CHECK write: PASS_COUNT or FAIL_COUNT increments; both saturate at all-ones.
- STATUS (addr 3) write is ignored.
- BUS_WE and BUS_RE both high: both actions are performed.
- Read:
  - BUS_RE with addr 3 loads BUS_DATA_OUT next edge with {zero-pad, state[1:0], OVERFLOW, full, empty}, with empty at bit 0.
  - RE with any other address loads 0.
  - No RE: BUS_DATA_OUT holds its value.
- FIFO:
  - OUT_DATA/OUT_VALID driven from registers only.
  - First-word latency: a char pushed at edge N is visible after edge N, poppable at edge N+1.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.
  - Drain continues in DRAIN and DONE states; DONE implies OUT_VALID=0.
- Encodings: RUN=0, DRAIN=1, DONE=2.
- ALL_OK, combinational: (FAIL_COUNT==0) & !OVERFLOW & (state!=DONE | EXIT_CODE==0).

Decomposition:
- Package dbg_port_pkg:
  - state enum {RUN, DRAIN, DONE} with the fixed encodings above.
  - Register address constants ADDR_CHAR/CHECK/HALT/STATUS.
  - STATUS bit index constants.
- Sub-module dbg_fifo, parameterised by depth and width: push/pop, full/empty, head output.
- dbg_port instantiates dbg_fifo and holds the FSM, counters and bus logic.

Test Plan:
- Reset mid-stream: push 3 chars, assert RST between edges -> OUT_VALID=0 at once; counters 0, DONE=0, ALL_OK=1 after release.
- Console ordering: OUT_READY=0, write CHAR 0x48,0x69 -> OUT_DATA=0x48, OUT_VALID=1; raise OUT_READY -> 0x48 then 0x69 popped on consecutive edges, then OUT_VALID=0.
- Overflow with FIFO_DEPTH=4, OUT_READY=0: write 5 CHARs -> OVERFLOW=1, ALL_OK=0, STATUS read = 0x06 (full=1, empty=0). Then with FIFO still full, OUT_READY=1 plus a CHAR write on the same edge -> accepted, occupancy stays 4.
- Checks: 3 CHECK writes of 0x01 and 1 of 0x00 -> PASS_COUNT=3, FAIL_COUNT=1, ALL_OK=0. With COUNT_WIDTH=2, 5 passes -> PASS_COUNT=3 (saturated).
- Halt with backlog: 2 chars queued, OUT_READY=0, HALT 0x00 -> STATUS state=DRAIN, DONE=0. Later CHAR/CHECK writes ignored. Release OUT_READY -> DONE=1 the edge after the FIFO empties, EXIT_CODE=0, ALL_OK=1.
- Nonzero exit: empty FIFO, HALT 0x2A -> DONE=1 one edge later, EXIT_CODE=0x2A, ALL_OK=0. A further HALT 0x00 changes nothing.
